// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
//   Shared definitions for the Common Data Bus arbiter slice:
//   - default width / size constants used as parameter defaults
//   - cdb_pkt_t : one broadcast result {tag, data, dest_reg} at default widths
//   - rr_next() : round-robin successor of a source index
//   No ports (package).
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int CDB_DATA_WIDTH          = 32;
  localparam int CDB_PHYS_REG_ADDR_WIDTH = 6;
  localparam int CDB_TAG_WIDTH           = 3;
  localparam int CDB_NUM_SRC             = 4;
  localparam int CDB_NUM_LANES           = 3;
  localparam int CDB_FIFO_DEPTH          = 2;

  typedef struct packed {
    logic [CDB_TAG_WIDTH-1:0]           tag;
    logic [CDB_DATA_WIDTH-1:0]          data;
    logic [CDB_PHYS_REG_ADDR_WIDTH-1:0] dest_reg;
  } cdb_pkt_t;

  // Index of the source following 'ptr' in a ring of 'num_src' sources.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned num_src);
    return (ptr + 1 >= num_src) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//   Producer-side handshake bundle and CDB broadcast lanes of the arbiter.
//   Signals:
//     src_valid_i / src_ready_o      per-producer valid/ready handshake
//     src_tag_i / src_data_i /
//     src_dest_reg_i                 per-producer result payload
//     cdb_valid_o                    per-lane broadcast valid (one-cycle pulse)
//     cdb_tag_o / cdb_data_o /
//     cdb_dest_reg_o / cdb_src_id_o  per-lane broadcast payload and winner id
//   Modports:
//     master : producers and CDB listeners (drive src_*, observe cdb_*)
//     slave  : the arbiter
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int DATA_WIDTH          = CDB_DATA_WIDTH,
  parameter int PHYS_REG_ADDR_WIDTH = CDB_PHYS_REG_ADDR_WIDTH,
  parameter int TAG_WIDTH           = CDB_TAG_WIDTH,
  parameter int NUM_SRC             = CDB_NUM_SRC,
  parameter int NUM_LANES           = CDB_NUM_LANES
) ();

  localparam int SRC_ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                                src_valid_i;
  logic [NUM_SRC-1:0]                                src_ready_o;
  logic [NUM_SRC-1:0][TAG_WIDTH-1:0]                 src_tag_i;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]                src_data_i;
  logic [NUM_SRC-1:0][PHYS_REG_ADDR_WIDTH-1:0]       src_dest_reg_i;

  logic [NUM_LANES-1:0]                              cdb_valid_o;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]               cdb_tag_o;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]              cdb_data_o;
  logic [NUM_LANES-1:0][PHYS_REG_ADDR_WIDTH-1:0]     cdb_dest_reg_o;
  logic [NUM_LANES-1:0][SRC_ID_W-1:0]                cdb_src_id_o;

  modport master (
    output src_valid_i, src_tag_i, src_data_i, src_dest_reg_i,
    input  src_ready_o,
    input  cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_dest_reg_o, cdb_src_id_o
  );

  modport slave (
    input  src_valid_i, src_tag_i, src_data_i, src_dest_reg_i,
    output src_ready_o,
    output cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_dest_reg_o, cdb_src_id_o
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
//   Small per-producer result FIFO. Pointers wrap naturally; a separate count
//   (one bit wider than the pointers) distinguishes full from empty.
//   A push into a full FIFO is ignored even when the same cycle pops, so there
//   is no pass-through path. flush_i empties the FIFO and discards the pushes
//   and pops of that cycle.
//   Ports:
//     clk, reset   clock, synchronous active-low reset
//     push_i       write pkt_i at the tail (ignored when full)
//     pkt_i        packet to write
//     pop_i        drop the head entry (ignored when empty)
//     flush_i      discard all entries
//     pkt_o        current head entry
//     empty_o      no entries (from registered count)
//     full_o       DEPTH entries (from registered count)
// -----------------------------------------------------------------------------
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pkt_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] pkt_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign pkt_o   = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, since reads are qualified by the reset count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= pkt_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common Data Bus arbiter. NUM_SRC producers each feed a cdb_src_fifo; every
//   cycle a round-robin scan starting at rr_ptr grants up to NUM_LANES
//   non-empty FIFO heads. The n-th winner in scan order is registered onto
//   lane n; unused lanes are driven all-zero. rr_ptr moves past the last
//   winner. Lanes update every cycle (one-cycle valid pulse per broadcast).
//   Ports:
//     clk, reset           clock, synchronous active-low reset
//     flush_i              discard all buffered results (rr_ptr kept)
//     bus (slave)          producer handshake + CDB lanes, see cdb_arbiter_if
//     perf_conflict_cnt_o  [CDB_ARB_PERF_EN only] saturating count of cycles
//                          with more than NUM_LANES non-empty FIFOs
//   Build option: define CDB_ARB_PERF_EN to add the conflict counter.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_WIDTH          = CDB_DATA_WIDTH,
  parameter int PHYS_REG_ADDR_WIDTH = CDB_PHYS_REG_ADDR_WIDTH,
  parameter int TAG_WIDTH           = CDB_TAG_WIDTH,
  parameter int NUM_SRC             = CDB_NUM_SRC,
  parameter int NUM_LANES           = CDB_NUM_LANES,
  parameter int FIFO_DEPTH          = CDB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt_o
`endif
);

  localparam int SRC_ID_W   = $clog2(NUM_SRC);
  localparam int LANE_CNT_W = $clog2(NUM_LANES + 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]           tag;
    logic [DATA_WIDTH-1:0]          data;
    logic [PHYS_REG_ADDR_WIDTH-1:0] dest_reg;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

  // ---------------------------------------------------------------------------
  // Per-source FIFOs
  // ---------------------------------------------------------------------------
  pkt_t               src_pkt  [NUM_SRC];
  pkt_t               head_pkt [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  // Ready depends only on registered counts plus the flush/reset inputs, so
  // producers never see a combinational path from the arbitration.
  assign bus.src_ready_o = ~fifo_full & {NUM_SRC{reset & ~flush_i}};
  assign push            = bus.src_valid_i & bus.src_ready_o;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_pkt[g] = '{tag:      bus.src_tag_i[g],
                          data:     bus.src_data_i[g],
                          dest_reg: bus.src_dest_reg_i[g]};

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PKT_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[g]),
      .pkt_i   (src_pkt[g]),
      .pop_i   (grant[g]),
      .flush_i (flush_i),
      .pkt_o   (head_pkt[g]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin multi-grant arbitration (from registered FIFO state)
  // ---------------------------------------------------------------------------
  logic [SRC_ID_W-1:0]                 rr_ptr_q;
  logic [SRC_ID_W-1:0]                 rr_ptr_d;
  logic [NUM_LANES-1:0]                lane_vld_d;
  logic [NUM_LANES-1:0][SRC_ID_W-1:0]  lane_id_d;
  pkt_t                                lane_pkt_d [NUM_LANES];

  always_comb begin
    logic [SRC_ID_W:0]     pos;
    logic [SRC_ID_W-1:0]   idx;
    logic [LANE_CNT_W-1:0] n_win;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant      = '0;
    lane_vld_d = '0;
    lane_id_d  = '0;
    for (int l = 0; l < NUM_LANES; l++) lane_pkt_d[l] = '0;
    rr_ptr_d   = rr_ptr_q;
    pos        = '0;
    idx        = '0;
    n_win      = '0;

    for (int k = 0; k < NUM_SRC; k++) begin
      // Scan position k maps to source (rr_ptr + k) mod NUM_SRC.
      pos = {1'b0, rr_ptr_q} + (SRC_ID_W + 1)'(k);
      if (pos >= (SRC_ID_W + 1)'(NUM_SRC)) pos = pos - (SRC_ID_W + 1)'(NUM_SRC);
      idx = pos[SRC_ID_W-1:0];

      if (!fifo_empty[idx] && (n_win < LANE_CNT_W'(NUM_LANES))) begin
        grant[idx] = 1'b1;
        // The n-th winner lands on lane n; constant lane indices keep the
        // selection a plain mux per lane.
        for (int l = 0; l < NUM_LANES; l++) begin
          if (n_win == LANE_CNT_W'(l)) begin
            lane_vld_d[l] = 1'b1;
            lane_id_d[l]  = idx;
            lane_pkt_d[l] = head_pkt[idx];
          end
        end
        rr_ptr_d = SRC_ID_W'(rr_next(32'(idx), NUM_SRC));
        n_win    = n_win + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered CDB lanes and round-robin pointer
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0]               cdb_valid_q;
  logic [NUM_LANES-1:0][SRC_ID_W-1:0] lane_id_q;
  pkt_t                               lane_pkt_q [NUM_LANES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      lane_id_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_pkt_q[l] <= '0;
    end else if (flush_i) begin
      // The pops of a flush cycle are discarded, so the pointer stays put.
      cdb_valid_q <= '0;
      lane_id_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_pkt_q[l] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= lane_vld_d;
      lane_id_q   <= lane_id_d;
      for (int l = 0; l < NUM_LANES; l++) lane_pkt_q[l] <= lane_pkt_d[l];
    end
  end

  always_comb begin
    bus.cdb_valid_o  = cdb_valid_q;
    bus.cdb_src_id_o = lane_id_q;
    bus.cdb_tag_o      = '0;
    bus.cdb_data_o     = '0;
    bus.cdb_dest_reg_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.cdb_tag_o[l]      = lane_pkt_q[l].tag;
      bus.cdb_data_o[l]     = lane_pkt_q[l].data;
      bus.cdb_dest_reg_o[l] = lane_pkt_q[l].dest_reg;
    end
  end

`ifdef CDB_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Conflict counter: cycles where demand exceeds the lane count (pre-pop).
  // Survives flush; saturates rather than wrapping.
  // ---------------------------------------------------------------------------
  localparam int BUSY_W = $clog2(NUM_SRC + 1);

  logic [BUSY_W-1:0] n_busy;
  logic [31:0]       perf_q;

  always_comb begin
    n_busy = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      n_busy = n_busy + BUSY_W'(!fifo_empty[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= '0;
    end else if ((n_busy > BUSY_W'(NUM_LANES)) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_conflict_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter at default parameters. Inputs change on the
//   falling edge, outputs are sampled on the falling edge. Expected lane
//   contents are worked out by hand from the round-robin rules.
//   Define CDB_ARB_PERF_EN to also exercise the conflict counter.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk;
  logic reset;
  logic flush_i;
`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter_if #(
    .DATA_WIDTH          (CDB_DATA_WIDTH),
    .PHYS_REG_ADDR_WIDTH (CDB_PHYS_REG_ADDR_WIDTH),
    .TAG_WIDTH           (CDB_TAG_WIDTH),
    .NUM_SRC             (CDB_NUM_SRC),
    .NUM_LANES           (CDB_NUM_LANES)
  ) bus ();

  cdb_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .bus                 (bus)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_conflict_cnt_o (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic cdb_pkt_t mk(input logic [2:0] tag, input logic [31:0] data,
                                  input logic [5:0] dest);
    mk = '{tag: tag, data: data, dest_reg: dest};
  endfunction

  localparam cdb_pkt_t ZERO_PKT = '0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_src(input logic [1:0] i, input cdb_pkt_t p);
    bus.src_valid_i[i]    = 1'b1;
    bus.src_tag_i[i]      = p.tag;
    bus.src_data_i[i]     = p.data;
    bus.src_dest_reg_i[i] = p.dest_reg;
  endtask

  task automatic clear_src();
    bus.src_valid_i    = '0;
    bus.src_tag_i      = '0;
    bus.src_data_i     = '0;
    bus.src_dest_reg_i = '0;
  endtask

  task automatic check_lane(input string name, input logic [1:0] l,
                            input logic [1:0] id, input cdb_pkt_t p);
    check(name, {bus.cdb_src_id_o[l], bus.cdb_tag_o[l], bus.cdb_data_o[l],
                 bus.cdb_dest_reg_o[l]}, {id, p.tag, p.data, p.dest_reg});
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    flush_i = 1'b0;
    clear_src();
    step();
    step();
    check("rst_ready", bus.src_ready_o, 4'h0);
    check("rst_valid", bus.cdb_valid_o, 3'b000);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    flush_i = 1'b0;
    clear_src();

    // ---------------- reset state ----------------
    step();
    step();
    check("reset_ready", bus.src_ready_o, 4'h0);
    check("reset_valid", bus.cdb_valid_o, 3'b000);
    check("reset_payload", {|bus.cdb_tag_o, |bus.cdb_data_o, |bus.cdb_dest_reg_o,
                            |bus.cdb_src_id_o}, 4'b0000);
    reset = 1'b1;
    #1;
    check("ready_after_reset", bus.src_ready_o, 4'hF);

    // ---------------- T1: single push, 2-cycle latency ----------------
    set_src(2'd0, mk(3'd0, 32'hA5A5_0001, 6'd5));
    step();
    check("t1_not_yet", bus.cdb_valid_o, 3'b000);
    clear_src();
    step();
    check("t1_valid", bus.cdb_valid_o, 3'b001);
    check_lane("t1_lane0", 2'd0, 2'd0, mk(3'd0, 32'hA5A5_0001, 6'd5));
    check_lane("t1_lane1", 2'd1, 2'd0, ZERO_PKT);
    check_lane("t1_lane2", 2'd2, 2'd0, ZERO_PKT);
    step();
    check("t1_pulse", bus.cdb_valid_o, 3'b000);

    // ---------------- T2: all four push together ----------------
    do_reset();
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h2000_0000 + 32'(i), 6'(8 + i)));
    step();
    clear_src();
    step();
    check("t2_valid_a", bus.cdb_valid_o, 3'b111);
    check_lane("t2_a_lane0", 2'd0, 2'd0, mk(3'd0, 32'h2000_0000, 6'd8));
    check_lane("t2_a_lane1", 2'd1, 2'd1, mk(3'd1, 32'h2000_0001, 6'd9));
    check_lane("t2_a_lane2", 2'd2, 2'd2, mk(3'd2, 32'h2000_0002, 6'd10));
    set_src(2'd0, mk(3'd5, 32'h2000_0010, 6'd20));
    set_src(2'd3, mk(3'd6, 32'h2000_0013, 6'd23));
    step();
    clear_src();
    check("t2_valid_b", bus.cdb_valid_o, 3'b001);
    check_lane("t2_b_lane0", 2'd0, 2'd3, mk(3'd3, 32'h2000_0003, 6'd11));
    check_lane("t2_b_lane1", 2'd1, 2'd0, ZERO_PKT);
    step();
    // rr_ptr wrapped to 0, so src0 leads src3 here.
    check("t2_valid_c", bus.cdb_valid_o, 3'b011);
    check_lane("t2_c_lane0", 2'd0, 2'd0, mk(3'd5, 32'h2000_0010, 6'd20));
    check_lane("t2_c_lane1", 2'd1, 2'd3, mk(3'd6, 32'h2000_0013, 6'd23));

    // ---------------- T3: src1 backpressure and order ----------------
    do_reset();
    set_src(2'd1, mk(3'd1, 32'h3000_00D0, 6'd1));
    step();
    clear_src();
    set_src(2'd0, mk(3'd0, 32'h3000_00A0, 6'd16));
    set_src(2'd1, mk(3'd1, 32'h3000_0001, 6'd2));
    set_src(2'd2, mk(3'd2, 32'h3000_00A2, 6'd18));
    set_src(2'd3, mk(3'd3, 32'h3000_00A3, 6'd19));
    step();
    check("t3_valid_d", bus.cdb_valid_o, 3'b001);
    check_lane("t3_d_lane0", 2'd0, 2'd1, mk(3'd1, 32'h3000_00D0, 6'd1));
    check("t3_ready1_one", bus.src_ready_o[1], 1'b1);
    set_src(2'd0, mk(3'd0, 32'h3000_00B0, 6'd24));
    set_src(2'd1, mk(3'd1, 32'h3000_0002, 6'd3));
    set_src(2'd2, mk(3'd2, 32'h3000_00B2, 6'd26));
    set_src(2'd3, mk(3'd3, 32'h3000_00B3, 6'd27));
    step();
    check("t3_valid_a", bus.cdb_valid_o, 3'b111);
    check_lane("t3_a_lane0", 2'd0, 2'd2, mk(3'd2, 32'h3000_00A2, 6'd18));
    check_lane("t3_a_lane1", 2'd1, 2'd3, mk(3'd3, 32'h3000_00A3, 6'd19));
    check_lane("t3_a_lane2", 2'd2, 2'd0, mk(3'd0, 32'h3000_00A0, 6'd16));
    check("t3_ready1_full", bus.src_ready_o, 4'b1101);
    clear_src();
    set_src(2'd1, mk(3'd1, 32'h3000_0003, 6'd4));
    step();
    check("t3_valid_p1", bus.cdb_valid_o, 3'b111);
    check_lane("t3_p1_lane0", 2'd0, 2'd1, mk(3'd1, 32'h3000_0001, 6'd2));
    check_lane("t3_p1_lane1", 2'd1, 2'd2, mk(3'd2, 32'h3000_00B2, 6'd26));
    check_lane("t3_p1_lane2", 2'd2, 2'd3, mk(3'd3, 32'h3000_00B3, 6'd27));
    check("t3_ready1_back", bus.src_ready_o[1], 1'b1);
    step();
    clear_src();
    check("t3_valid_p2", bus.cdb_valid_o, 3'b011);
    check_lane("t3_p2_lane0", 2'd0, 2'd0, mk(3'd0, 32'h3000_00B0, 6'd24));
    check_lane("t3_p2_lane1", 2'd1, 2'd1, mk(3'd1, 32'h3000_0002, 6'd3));
    step();
    check("t3_valid_p3", bus.cdb_valid_o, 3'b001);
    check_lane("t3_p3_lane0", 2'd0, 2'd1, mk(3'd1, 32'h3000_0003, 6'd4));
    step();
    check("t3_drained", bus.cdb_valid_o, 3'b000);

    // ---------------- T4: flush with results buffered ----------------
    do_reset();
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h4000_00A0 + 32'(i), 6'(32 + i)));
    step();
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h4000_00B0 + 32'(i), 6'(40 + i)));
    step();
    check("t4_pre_valid", bus.cdb_valid_o, 3'b111);
    clear_src();
    flush_i = 1'b1;
    #1;
    check("t4_ready_in_flush", bus.src_ready_o, 4'h0);
    step();
    flush_i = 1'b0;
    check("t4_valid_after", bus.cdb_valid_o, 3'b000);
    check("t4_payload_after", {|bus.cdb_data_o, |bus.cdb_src_id_o}, 2'b00);
    #1;
    check("t4_all_empty", bus.src_ready_o, 4'hF);
    set_src(2'd0, mk(3'd0, 32'h4000_00C0, 6'd48));
    set_src(2'd3, mk(3'd3, 32'h4000_00C3, 6'd51));
    step();
    clear_src();
    check("t4_no_stale", bus.cdb_valid_o, 3'b000);
    step();
    // rr_ptr was 3 before the flush and is kept.
    check("t4_valid_new", bus.cdb_valid_o, 3'b011);
    check_lane("t4_new_lane0", 2'd0, 2'd3, mk(3'd3, 32'h4000_00C3, 6'd51));
    check_lane("t4_new_lane1", 2'd1, 2'd0, mk(3'd0, 32'h4000_00C0, 6'd48));
    step();
    check("t4_quiet_1", bus.cdb_valid_o, 3'b000);
    step();
    check("t4_quiet_2", bus.cdb_valid_o, 3'b000);

    // ---------------- T5: reset mid-stream ----------------
    do_reset();
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h5000_00A0 + 32'(i), 6'(i)));
    step();
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h5000_00B0 + 32'(i), 6'(4 + i)));
    step();
    check("t5_pre_valid", bus.cdb_valid_o, 3'b111);
    reset = 1'b0;
    #1;
    check("t5_ready_in_reset", bus.src_ready_o, 4'h0);
    step();
    check("t5_valid", bus.cdb_valid_o, 3'b000);
    check("t5_payload", {|bus.cdb_tag_o, |bus.cdb_data_o, |bus.cdb_dest_reg_o,
                         |bus.cdb_src_id_o}, 4'b0000);
    reset = 1'b1;
    clear_src();
    #1;
    check("t5_ready_after", bus.src_ready_o, 4'hF);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t5_quiet_%0d", c), bus.cdb_valid_o, 3'b000);
    end

`ifdef CDB_ARB_PERF_EN
    // ---------------- T6: conflict counter ----------------
    do_reset();
    check("t6_perf_reset", perf_cnt, 32'd0);
    for (int i = 0; i < 4; i++)
      set_src(2'(i), mk(3'(i), 32'h6000_0000 + 32'(i), 6'(i)));
    repeat (10) step();
    clear_src();
    step();
    check("t6_perf_10", perf_cnt, 32'd10);
    step();
    check("t6_perf_hold", perf_cnt, 32'd10);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t6_perf_flush", perf_cnt, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
